// File: rtl/sram_serial_ctrl.sv
// Serial-load SRAM row controller: shifts a word in beat by beat, then issues
// single-row write, read, or write-then-verify accesses to an external array.
module sram_serial_ctrl #(
  parameter int unsigned ROWS      = 16,
  parameter int unsigned COLS      = 8,
  parameter int unsigned SER_W     = 1,
  parameter int unsigned SENSE_CYC = 2,
  localparam int unsigned AW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [SER_W-1:0] serial_in,
  input  logic             shift,
  input  logic             load,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [AW-1:0]    addr,
  output logic             busy,
  output logic             word_ready,
  output logic             data_valid,
  output logic [COLS-1:0]  data_out,
  output logic             mismatch,
  output logic             addr_err,
  output logic [AW-1:0]    arr_addr,
  output logic             arr_we,
  output logic             arr_re,
  output logic [COLS-1:0]  arr_din,
  input  logic [COLS-1:0]  arr_dout
);

  localparam int unsigned BEATS = COLS / SER_W;
  localparam int unsigned CW    = $clog2(BEATS + 1);
  localparam int unsigned SW    = (SENSE_CYC > 1) ? $clog2(SENSE_CYC) : 1;

  localparam logic [CW-1:0] BeatsMax  = CW'(BEATS);
  localparam logic [SW-1:0] SenseLast = SW'(SENSE_CYC - 1);
  localparam logic [AW:0]   RowsLim   = (AW + 1)'(ROWS);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [SW-1:0]   r_sense, w_sense_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic [COLS-1:0] r_sreg, r_wbuf, w_sreg_shifted;
  logic            r_verify;
  logic            r_busy, r_word_ready, r_data_valid, r_mismatch, r_addr_err;
  logic            r_arr_we, r_arr_re;
  logic [COLS-1:0] r_data_out, r_arr_din;
  logic [AW-1:0]   r_arr_addr;
  logic            w_req, w_addr_ok, w_accept, w_sample;

  assign w_sreg_shifted = (r_sreg << SER_W) | COLS'(serial_in);

  // Load wins the count reset; a simultaneous shift then counts as the first new beat.
  always_comb begin
    w_cnt_d = r_cnt;
    if (load) begin
      w_cnt_d = shift ? CW'(1) : '0;
    end else if (shift && (r_cnt != BeatsMax)) begin
      w_cnt_d = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sreg       <= '0;
      r_wbuf       <= '0;
      r_cnt        <= '0;
      r_word_ready <= 1'b0;
    end else begin
      if (shift) r_sreg <= w_sreg_shifted;
      if (load)  r_wbuf <= r_sreg;
      r_cnt        <= w_cnt_d;
      r_word_ready <= (w_cnt_d == BeatsMax);
    end
  end

  assign w_req     = w_en | r_en;
  assign w_addr_ok = ({1'b0, addr} < RowsLim);
  assign w_accept  = (r_state == StIdle) && w_req && w_addr_ok;
  assign w_sample  = (r_state == StRead) && (r_sense == SenseLast);

  always_comb begin
    w_state_d = r_state;
    w_sense_d = r_sense;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = w_en ? StWrite : StRead;
          w_sense_d = '0;
        end
      end
      StWrite: begin
        w_state_d = r_verify ? StRead : StIdle;
        w_sense_d = '0;
      end
      StRead: begin
        if (w_sample) w_state_d = StDone;
        else          w_sense_d = r_sense + 1'b1;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Status and strobes are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= StIdle;
      r_sense      <= '0;
      r_verify     <= 1'b0;
      r_busy       <= 1'b0;
      r_arr_we     <= 1'b0;
      r_arr_re     <= 1'b0;
      r_data_valid <= 1'b0;
      r_addr_err   <= 1'b0;
      r_arr_addr   <= '0;
      r_arr_din    <= '0;
      r_data_out   <= '0;
      r_mismatch   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_sense      <= w_sense_d;
      r_busy       <= (w_state_d != StIdle);
      r_arr_we     <= (w_state_d == StWrite);
      r_arr_re     <= (w_state_d == StRead);
      r_data_valid <= (w_state_d == StDone);
      r_addr_err   <= (r_state == StIdle) && w_req && !w_addr_ok;
      if (w_accept) begin
        r_arr_addr <= addr;
        r_arr_din  <= r_wbuf;
        r_verify   <= w_en & r_en;
      end
      if (w_sample) begin
        r_data_out <= arr_dout;
        r_mismatch <= r_verify && (arr_dout != r_arr_din);
      end
    end
  end

  assign busy       = r_busy;
  assign word_ready = r_word_ready;
  assign data_valid = r_data_valid;
  assign data_out   = r_data_out;
  assign mismatch   = r_mismatch;
  assign addr_err   = r_addr_err;
  assign arr_addr   = r_arr_addr;
  assign arr_we     = r_arr_we;
  assign arr_re     = r_arr_re;
  assign arr_din    = r_arr_din;

endmodule

// File: tb/tb_sram_serial_ctrl.sv
// Directed bench for sram_serial_ctrl: table-driven shift/load vectors plus
// hand-written write, read, write-verify, address-error and reset sequences.
module tb_sram_serial_ctrl;

  localparam int unsigned ROWS  = 12;
  localparam int unsigned COLS  = 8;
  localparam int unsigned SER_W = 1;
  localparam int unsigned SENSE = 2;
  localparam int unsigned AW    = 4;

  logic             clk, arst_n;
  logic [SER_W-1:0] serial_in;
  logic             shift, load, w_en, r_en;
  logic [AW-1:0]    addr;
  logic             busy, word_ready, data_valid, mismatch, addr_err, arr_we, arr_re;
  logic [COLS-1:0]  data_out, arr_din, arr_dout;
  logic [AW-1:0]    arr_addr;

  int checks, errors;
  int lat, wc, rc, cnt;

  typedef struct packed {
    logic sh;
    logic sin;
    logic ld;
    logic rdy;
  } vec_t;

  vec_t vecs [0:25];
  int   nvec;

  sram_serial_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SER_W(SER_W), .SENSE_CYC(SENSE)
  ) dut (
    .clk(clk), .arst_n(arst_n), .serial_in(serial_in), .shift(shift), .load(load),
    .w_en(w_en), .r_en(r_en), .addr(addr), .busy(busy), .word_ready(word_ready),
    .data_valid(data_valid), .data_out(data_out), .mismatch(mismatch),
    .addr_err(addr_err), .arr_addr(arr_addr), .arr_we(arr_we), .arr_re(arr_re),
    .arr_din(arr_din), .arr_dout(arr_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic sh, input logic sin, input logic ld, input logic rdy);
    vecs[nvec].sh  = sh;
    vecs[nvec].sin = sin;
    vecs[nvec].ld  = ld;
    vecs[nvec].rdy = rdy;
    nvec++;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      shift     = vecs[i].sh;
      serial_in = vecs[i].sin;
      load      = vecs[i].ld;
      step();
      chk1($sformatf("word_ready[%0d]", i), word_ready, vecs[i].rdy);
    end
    shift     = 1'b0;
    serial_in = '0;
    load      = 1'b0;
  endtask

  // Issues one command, then waits (bounded) for data_valid, counting array strobes.
  task automatic run_cmd(input logic we, input logic re, input logic [AW-1:0] a,
                         output int l, output int nw, output int nr);
    w_en = we;
    r_en = re;
    addr = a;
    step();
    w_en = 1'b0;
    r_en = 1'b0;
    l  = -1;
    nw = 0;
    nr = 0;
    for (int k = 0; k < 20; k++) begin
      if (arr_we) nw++;
      if (arr_re) nr++;
      if (arr_we && arr_re) chk1("we_re_exclusive", 1'b1, 1'b0);
      if (data_valid) begin
        l = k;
        break;
      end
      step();
    end
  endtask

  task automatic finish_dv(input string tag, input logic [COLS-1:0] exp_dout);
    step();
    chk1({tag, "_dv_one_cycle"}, data_valid, 1'b0);
    chk1({tag, "_idle_after"}, busy, 1'b0);
    chkw({tag, "_dout_held"}, 32'(data_out), 32'(exp_dout));
  endtask

  initial begin
    checks = 0; errors = 0; nvec = 0;
    arst_n = 1'b0; serial_in = '0; shift = 1'b0; load = 1'b0;
    w_en = 1'b0; r_en = 1'b0; addr = '0; arr_dout = '0;

    // Phase 1: 0xA5 MSB-first, then load.
    add_vec(1, 1, 0, 0); add_vec(1, 0, 0, 0); add_vec(1, 1, 0, 0); add_vec(1, 0, 0, 0);
    add_vec(1, 0, 0, 0); add_vec(1, 1, 0, 0); add_vec(1, 0, 0, 0); add_vec(1, 1, 0, 1);
    add_vec(0, 0, 1, 0);
    // Phase 2: 0x3C, saturating shift (0x79), load+shift, then seven more beats.
    add_vec(1, 0, 0, 0); add_vec(1, 0, 0, 0); add_vec(1, 1, 0, 0); add_vec(1, 1, 0, 0);
    add_vec(1, 1, 0, 0); add_vec(1, 1, 0, 0); add_vec(1, 0, 0, 0); add_vec(1, 0, 0, 1);
    add_vec(1, 1, 0, 1);
    add_vec(1, 0, 1, 0);
    add_vec(1, 0, 0, 0); add_vec(1, 0, 0, 0); add_vec(1, 0, 0, 0); add_vec(1, 0, 0, 0);
    add_vec(1, 0, 0, 0); add_vec(1, 0, 0, 0); add_vec(1, 0, 0, 1);

    #12;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_word_ready", word_ready, 1'b0);
    chk1("rst_data_valid", data_valid, 1'b0);
    chkw("rst_data_out", 32'(data_out), 32'h0);
    chk1("rst_mismatch", mismatch, 1'b0);
    chk1("rst_addr_err", addr_err, 1'b0);
    chkw("rst_arr_addr", 32'(arr_addr), 32'h0);
    chk1("rst_arr_we", arr_we, 1'b0);
    chk1("rst_arr_re", arr_re, 1'b0);
    chkw("rst_arr_din", 32'(arr_din), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;

    apply_vecs(0, 9);

    // Plain write of 0xA5 to row 3.
    w_en = 1'b1; addr = 4'd3;
    step();
    w_en = 1'b0;
    chk1("wr_arr_we", arr_we, 1'b1);
    chk1("wr_arr_re", arr_re, 1'b0);
    chk1("wr_busy", busy, 1'b1);
    chkw("wr_arr_addr", 32'(arr_addr), 32'd3);
    chkw("wr_arr_din", 32'(arr_din), 32'hA5);
    step();
    chk1("wr_we_one_cycle", arr_we, 1'b0);
    chk1("wr_idle_after", busy, 1'b0);

    // Plain read of row 3.
    arr_dout = 8'h3C;
    run_cmd(1'b0, 1'b1, 4'd3, lat, wc, rc);
    chkw("rd_latency", lat, SENSE);
    chkw("rd_re_cycles", rc, SENSE);
    chkw("rd_we_cycles", wc, 0);
    chkw("rd_data_out", 32'(data_out), 32'h3C);
    chk1("rd_mismatch", mismatch, 1'b0);
    finish_dv("rd", 8'h3C);

    // Write-verify with a corrupted readback.
    arr_dout = 8'hA4;
    run_cmd(1'b1, 1'b1, 4'd5, lat, wc, rc);
    chkw("wv_bad_latency", lat, SENSE + 1);
    chkw("wv_bad_we_cycles", wc, 1);
    chkw("wv_bad_re_cycles", rc, SENSE);
    chkw("wv_bad_arr_addr", 32'(arr_addr), 32'd5);
    chkw("wv_bad_data_out", 32'(data_out), 32'hA4);
    chk1("wv_bad_mismatch", mismatch, 1'b1);
    finish_dv("wv_bad", 8'hA4);
    chk1("wv_bad_mismatch_held", mismatch, 1'b1);

    // A plain read clears the sticky mismatch.
    arr_dout = 8'h3C;
    run_cmd(1'b0, 1'b1, 4'd5, lat, wc, rc);
    chk1("rd_clears_mismatch", mismatch, 1'b0);
    finish_dv("rd2", 8'h3C);

    // Write-verify with a clean readback.
    arr_dout = 8'hA5;
    run_cmd(1'b1, 1'b1, 4'd5, lat, wc, rc);
    chkw("wv_ok_latency", lat, SENSE + 1);
    chkw("wv_ok_data_out", 32'(data_out), 32'hA5);
    chk1("wv_ok_mismatch", mismatch, 1'b0);
    finish_dv("wv_ok", 8'hA5);

    // Out-of-range row is rejected.
    w_en = 1'b1; addr = 4'd13;
    step();
    w_en = 1'b0;
    chk1("aerr_pulse", addr_err, 1'b1);
    chk1("aerr_busy", busy, 1'b0);
    chk1("aerr_no_we", arr_we, 1'b0);
    chkw("aerr_addr_kept", 32'(arr_addr), 32'd5);
    step();
    chk1("aerr_one_cycle", addr_err, 1'b0);
    chk1("aerr_busy2", busy, 1'b0);
    chk1("aerr_no_we2", arr_we, 1'b0);

    // Write-verify with a mid-flight load of 0xFF and a held r_en to another row.
    shift = 1'b1; serial_in = 1'b1;
    repeat (8) step();
    shift = 1'b0; serial_in = '0;
    arr_dout = 8'hA5;
    w_en = 1'b1; r_en = 1'b1; addr = 4'd5;
    step();
    w_en = 1'b0; addr = 4'd2; load = 1'b1;
    step();
    load = 1'b0;
    lat = -1; cnt = 0;
    for (int k = 1; k < 20; k++) begin
      if (arr_addr != 4'd5) cnt++;
      if (data_valid) begin
        lat = k;
        break;
      end
      step();
    end
    r_en = 1'b0;
    chkw("ovl_latency", lat, SENSE + 1);
    chkw("ovl_addr_changes", cnt, 0);
    chkw("ovl_arr_din", 32'(arr_din), 32'hA5);
    chkw("ovl_data_out", 32'(data_out), 32'hA5);
    chk1("ovl_mismatch", mismatch, 1'b0);
    step();
    chk1("ovl_req_ignored", busy, 1'b0);
    chk1("ovl_no_re", arr_re, 1'b0);

    apply_vecs(9, 26);

    // Load+shift captured the pre-shift register (0x79).
    w_en = 1'b1; addr = 4'd7;
    step();
    w_en = 1'b0;
    chk1("ldsh_we", arr_we, 1'b1);
    chkw("ldsh_arr_din", 32'(arr_din), 32'h79);
    step();

    // Reset in the middle of a read.
    arr_dout = 8'h3C;
    r_en = 1'b1; addr = 4'd1;
    step();
    r_en = 1'b0;
    chk1("mrst_re_before", arr_re, 1'b1);
    #2;
    arst_n = 1'b0;
    #1;
    chk1("mrst_re_drop", arr_re, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_dv", data_valid, 1'b0);
    chk1("mrst_word_ready", word_ready, 1'b0);
    chkw("mrst_data_out", 32'(data_out), 32'h0);
    chkw("mrst_arr_addr", 32'(arr_addr), 32'h0);
    chkw("mrst_arr_din", 32'(arr_din), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      step();
      if (data_valid || busy) cnt++;
    end
    chkw("mrst_no_dv_after", cnt, 0);

    // Command on the very first edge after release.
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1; r_en = 1'b1; addr = 4'd3;
    step();
    r_en = 1'b0;
    chk1("rel_re", arr_re, 1'b1);
    chk1("rel_busy", busy, 1'b1);
    chkw("rel_arr_addr", 32'(arr_addr), 32'd3);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (data_valid) begin
        lat = k;
        break;
      end
      step();
    end
    chkw("rel_latency", lat, SENSE);
    chkw("rel_data_out", 32'(data_out), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_serial_ctrl.md
SRAM_SERIAL_CTRL -- requirements
Module: sram_serial_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of array rows.
REQ-002 SHALL have parameter COLS, default 8, word width in bits.
REQ-003 SHALL have parameter SER_W, default 1, bits per shift beat; COLS % SER_W == 0.
REQ-004 SHALL have parameter SENSE_CYC, default 2, read-enable cycles before sampling (>=1).
REQ-005 SHALL have ports:
  clk  in  1  single clock, rising edge.
  arst_n  in  1  reset, asynchronous, active-low.
  serial_in  in  SER_W  serial data beat.
  shift  in  1  shift one beat into shift register.
  load  in  1  copy shift register to write buffer.
  w_en  in  1  write request.
  r_en  in  1  read request.
  addr  in  $clog2(ROWS)  target row.
  busy  out  1  command in progress.
  word_ready  out  1  COLS/SER_W beats collected since last load.
  data_valid  out  1  one-cycle read-data strobe.
  data_out  out  COLS  read data.
  mismatch  out  1  write-verify compare failed.
  addr_err  out  1  one-cycle pulse, command rejected for addr >= ROWS.
  arr_addr  out  $clog2(ROWS)  array row address.
  arr_we  out  1  array write enable.
  arr_re  out  1  array read enable.
  arr_din  out  COLS  array write data.
  arr_dout  in  COLS  array read data.

Function
REQ-006 SHALL, on shift, update sreg <= {sreg[COLS-SER_W-1:0], serial_in} (MSB-first) and increment beat count, saturating at COLS/SER_W.
REQ-007 SHALL assert word_ready when beat count == COLS/SER_W.
REQ-008 SHALL, on load, set wbuf <= sreg and clear beat count; load+shift in the same cycle: wbuf takes pre-shift sreg, shift applies, count becomes 1.
REQ-009 SHALL accept shift and load in any state, including while busy.
REQ-010 SHALL accept w_en/r_en only in IDLE; requests while busy are ignored with no side effect.
REQ-011 SHALL, on acceptance, latch addr into arr_addr and wbuf into arr_din and compare reference; later loads do not affect an in-flight command.
REQ-012 SHALL reject a command with addr >= ROWS: pulse addr_err next cycle, remain IDLE, no array access.
REQ-013 SHALL implement FSM states IDLE, WRITE, READ, DONE.
REQ-014 SHALL on w_en only go IDLE->WRITE: arr_we=1 for exactly one cycle, then IDLE.
REQ-015 SHALL on r_en only go IDLE->READ: arr_re=1 for SENSE_CYC cycles; on the last cycle sample arr_dout into data_out; then DONE.
REQ-016 SHALL on w_en and r_en together (write-verify) go IDLE->WRITE->READ->DONE at the same address.
REQ-017 SHALL in DONE pulse data_valid for one cycle, then return to IDLE.
REQ-018 SHALL give latency: request accepted at edge T; read-only data_valid high in cycle T+SENSE_CYC+1; write-verify data_valid in cycle T+SENSE_CYC+2.
REQ-019 SHALL in write-verify set mismatch = (sampled data != latched write data), updated with data_valid and held until the next data_valid.
REQ-020 SHALL clear mismatch on a plain read's data_valid.
REQ-021 SHALL hold data_out stable between data_valid pulses.
REQ-022 SHALL assert busy whenever state != IDLE; arr_we and arr_re never high in the same cycle.
REQ-023 SHALL drive all outputs from registers.

Reset
REQ-024 SHALL on arst_n low immediately force state IDLE and zero: sreg, wbuf, beat count, busy, word_ready, data_valid, data_out, mismatch, addr_err, arr_addr, arr_we, arr_re, arr_din.
REQ-025 SHALL, on reset mid-operation, drop arr_we/arr_re asynchronously and emit no data_valid after release.
REQ-026 SHALL accept a command on the first edge after arst_n deasserts.

Verification
REQ-027 COLS=8, SER_W=1: 8 shifts of 0xA5 MSB-first, load, w_en addr 3 -> word_ready after 8th shift; arr_we one cycle, arr_addr=3, arr_din=0xA5.
REQ-028 SENSE_CYC=2, r_en addr 3, arr_dout=0x3C -> arr_re high 2 cycles, data_valid in cycle T+3, data_out=0x3C, mismatch=0.
REQ-029 Write-verify 0xA5 addr 5, array model returns 0xA4 -> data_valid at T+4, data_out=0xA4, mismatch=1; repeat returning 0xA5 -> mismatch=0.
REQ-030 ROWS=12, w_en addr 13 -> addr_err pulse, arr_we never high, busy stays 0.
REQ-031 r_en during READ, plus load of 0xFF mid-write-verify -> second request ignored; compare still uses original data.
REQ-032 arst_n low during READ -> arr_re drops immediately, all outputs 0, no data_valid; r_en next edge after release accepted.
